// File: rtl/sbc_bus_ctrl.sv
// sbc_bus_ctrl: base/mask region decoder, access sequencer and interrupt combiner between the 6502 core and its slaves.
// Latency: cpu_rdy 3+W cycles after cpu_req, where W is the region's wait-state count; cpu_irq_n lags the sources by one cycle.
// Backpressure: one access in flight; cpu_req is sampled only in IDLE (which includes the cpu_rdy cycle) and dropped otherwise.
// Optional: define SBC_BUS_IRQ_REG_EN to add the interrupt pending/enable register at IRQ_REG_ADDR.
module sbc_bus_ctrl #(
    parameter int                              ADDR_W       = 16,
    parameter int                              DATA_W       = 8,
    parameter int                              NUM_REGIONS  = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE  = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_MASK  = {16'hC000, 16'hFFFC, 16'hC000, 16'h8000},
    parameter logic [NUM_REGIONS*4-1:0]        REGION_WAIT  = {4'd0, 4'd2, 4'd0, 4'd0},
    parameter int                              NUM_IRQ      = 2,
    parameter logic [DATA_W-1:0]               OPEN_BUS     = 8'hFF,
    parameter logic [ADDR_W-1:0]               IRQ_REG_ADDR = 16'h7FF0
) (
    input  logic                          fst_clk,
    input  logic                          res_n,
    input  logic                          cpu_req,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic                          cpu_rw_n,
    input  logic [DATA_W-1:0]             cpu_dout,
    output logic [DATA_W-1:0]             cpu_din,
    output logic                          cpu_rdy,
    output logic                          cpu_irq_n,
    output logic [NUM_REGIONS-1:0]        sel_n,
    output logic                          rd_en,
    output logic                          wr_en,
    output logic [DATA_W-1:0]             wr_data,
    input  logic [NUM_REGIONS*DATA_W-1:0] rgn_dout,
    input  logic [NUM_IRQ-1:0]            irq_src_n
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state;
    logic               acc_hit;
    logic               acc_rd;
    logic [IDX_W-1:0]   acc_idx;
    logic [3:0]         acc_cnt;

    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic [3:0]         dec_wait;
    logic               req_hit;
    logic [3:0]         req_wait;
    logic [DATA_W-1:0]  rd_data;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_en;

    assign pending = ~irq_src_n;

`ifdef SBC_BUS_IRQ_REG_EN
    logic               acc_reg;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               dec_reg;

    assign dec_reg = (cpu_addr == IRQ_REG_ADDR);
    assign irq_en  = irq_mask;
`else
    assign irq_en  = '1;
`endif

    // Region decode: scan from the top so the lowest-index hit is the one left standing
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_wait = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((cpu_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) begin
                dec_hit  = 1'b1;
                dec_idx  = IDX_W'(i);
                dec_wait = REGION_WAIT[i*4 +: 4];
            end
        end
    end

    // The internal register, when present, shadows every region and always runs with zero wait states
    always_comb begin
        req_hit  = dec_hit;
        req_wait = dec_wait;
`ifdef SBC_BUS_IRQ_REG_EN
        if (dec_reg) begin
            req_hit  = 1'b0;
            req_wait = 4'd0;
        end
`endif
    end

    // Read-back mux: selected slave slice, internal register, or the open-bus value
    always_comb begin
        rd_data = acc_hit ? rgn_dout[int'(acc_idx)*DATA_W +: DATA_W] : OPEN_BUS;
`ifdef SBC_BUS_IRQ_REG_EN
        if (acc_reg) begin
            rd_data = DATA_W'(pending);
        end
`endif
    end

    // Access sequencer: IDLE latches the request, ACCESS burns wait states, DONE returns data and pulses cpu_rdy
    always_ff @(posedge fst_clk) begin
        if (!res_n) begin
            state   <= IDLE;
            acc_hit <= 1'b0;
            acc_rd  <= 1'b0;
            acc_idx <= '0;
            acc_cnt <= 4'd0;
            sel_n   <= '1;
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            wr_data <= '0;
            cpu_din <= '0;
            cpu_rdy <= 1'b0;
`ifdef SBC_BUS_IRQ_REG_EN
            acc_reg  <= 1'b0;
            irq_mask <= '1;
`endif
        end else begin
            cpu_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state   <= ACCESS;
                        acc_hit <= req_hit;
                        acc_rd  <= cpu_rw_n;
                        acc_idx <= dec_idx;
                        acc_cnt <= req_wait;
                        wr_data <= cpu_dout;
                        sel_n   <= req_hit ? ~(NUM_REGIONS'(1) << dec_idx) : '1;
                        rd_en   <= req_hit & cpu_rw_n;
                        wr_en   <= req_hit & ~cpu_rw_n;
`ifdef SBC_BUS_IRQ_REG_EN
                        acc_reg <= dec_reg;
`endif
                    end
                end
                ACCESS: begin
                    // write strobe lives for the first ACCESS cycle only
                    wr_en <= 1'b0;
                    if (acc_cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        acc_cnt <= acc_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    sel_n   <= '1;
                    rd_en   <= 1'b0;
                    cpu_rdy <= 1'b1;
                    if (acc_rd) begin
                        cpu_din <= rd_data;
                    end
`ifdef SBC_BUS_IRQ_REG_EN
                    if (acc_reg && !acc_rd) begin
                        irq_mask <= wr_data[NUM_IRQ-1:0];
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Level-sensitive interrupt combine, registered once
    always_ff @(posedge fst_clk) begin
        if (!res_n) begin
            cpu_irq_n <= 1'b1;
        end else begin
            cpu_irq_n <= ~|(pending & irq_en);
        end
    end

endmodule

// File: tb/tb_sbc_bus_ctrl.sv
// tb_sbc_bus_ctrl: randomized scoreboard bench for sbc_bus_ctrl with a transaction-level reference model.
// Latency: expected cpu_rdy at 3+W cycles after the accepted request; irq expected one cycle after the sources.
// Backpressure: stimulus issues one access at a time, optionally back-to-back in the cpu_rdy cycle, with stray req pulses while busy.
module tb_sbc_bus_ctrl;

    logic        fst_clk   = 1'b0;
    logic        res_n     = 1'b0;
    logic        cpu_req   = 1'b0;
    logic [15:0] cpu_addr  = 16'h0000;
    logic        cpu_rw_n  = 1'b1;
    logic [7:0]  cpu_dout  = 8'h00;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        cpu_irq_n;
    logic [3:0]  sel_n;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [31:0] rgn_dout  = 32'h0;
    logic [1:0]  irq_src_n = 2'b11;
    bit          req_real  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sbc_bus_ctrl dut (
        .fst_clk   (fst_clk),
        .res_n     (res_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_rw_n  (cpu_rw_n),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_rdy   (cpu_rdy),
        .cpu_irq_n (cpu_irq_n),
        .sel_n     (sel_n),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rgn_dout  (rgn_dout),
        .irq_src_n (irq_src_n)
    );

    always #5 fst_clk = ~fst_clk;

    // Memory map as written in the parameter list: region i = slice i
    localparam logic [15:0] M_BASE [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
    localparam logic [15:0] M_MASK [4] = '{16'h8000, 16'hC000, 16'hFFFC, 16'hC000};
    localparam int          M_WAIT [4] = '{0, 0, 2, 0};

    typedef struct {
        bit         rd;
        bit         reg_acc;
        logic [7:0] din;
        int         lat;
        logic [3:0] sel_mask;
        int         sel_cyc;
        int         rd_cyc;
        int         wr_cyc;
        logic [7:0] wdat;
    } txn_t;

    txn_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge fst_clk);
        #1;
    endtask

    function automatic void model_decode(input logic [15:0] a, output bit hit, output int idx,
                                         output int w, output bit is_reg);
        hit    = 1'b0;
        idx    = 0;
        w      = 0;
        is_reg = 1'b0;
`ifdef SBC_BUS_IRQ_REG_EN
        is_reg = (a == 16'h7FF0);
`endif
        if (!is_reg) begin
            for (int i = 0; i < 4; i++) begin
                if (!hit && ((a & M_MASK[i]) == (M_BASE[i] & M_MASK[i]))) begin
                    hit = 1'b1;
                    idx = i;
                    w   = M_WAIT[i];
                end
            end
        end
    endfunction

    // One CPU access: pulse req in cycle T, optionally spray ignored reqs while busy, return in the cpu_rdy cycle
    task automatic do_txn(input logic [15:0] a, input bit rd, input logic [7:0] wd,
                          input logic [31:0] rdv, input bit b2b, input bit junk);
        bit   hit;
        bit   is_reg;
        int   idx;
        int   w;
        txn_t t;
        model_decode(a, hit, idx, w, is_reg);
        t.rd       = rd;
        t.reg_acc  = is_reg;
        t.lat      = w + 3;
        t.sel_mask = hit ? 4'(1 << idx) : 4'h0;
        t.sel_cyc  = hit ? w + 2 : 0;
        t.rd_cyc   = (hit && rd) ? w + 2 : 0;
        t.wr_cyc   = (hit && !rd) ? 1 : 0;
        t.wdat     = wd;
        t.din      = hit ? rdv[idx*8 +: 8] : 8'hFF;
        q.push_back(t);
        cpu_req  = 1'b1;
        req_real = 1'b1;
        cpu_addr = a;
        cpu_rw_n = rd;
        cpu_dout = wd;
        rgn_dout = rdv;
        step();
        cpu_req  = 1'b0;
        req_real = 1'b0;
        for (int c = 1; c < t.lat; c++) begin
            if (junk && $urandom_range(0, 2) == 0) cpu_req = 1'b1;
            step();
            cpu_req = 1'b0;
        end
        if (!b2b) begin
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    // Region-2 read abandoned by a one-cycle reset at T+2; no scoreboard entry since no cpu_rdy may follow
    task automatic reset_mid();
        cpu_req  = 1'b1;
        req_real = 1'b1;
        cpu_addr = 16'h8002;
        cpu_rw_n = 1'b1;
        rgn_dout = $urandom;
        step();
        cpu_req  = 1'b0;
        req_real = 1'b0;
        step();
        res_n = 1'b0;
        step();
        res_n = 1'b1;
        repeat (3) step();
    endtask

    // Monitor: per-cycle accumulation of strobes, scoreboard pop on cpu_rdy, reset and interrupt checks
    int         nc = 0;
    int         start_nc = 0;
    logic [3:0] a_sel = 4'h0;
    int         a_selc = 0;
    int         a_rd = 0;
    int         a_wr = 0;
    logic [7:0] a_wd = 8'h00;
    logic [7:0] m_din = 8'h00;
    logic [1:0] m_mask = 2'b11;
    logic       prev_res = 1'b0;
    logic [1:0] prev_irq = 2'b11;

    always @(negedge fst_clk) begin
        txn_t t;
        nc++;
        if (!prev_res) begin
            chk("rst_sel_n", 32'(sel_n), 32'hF);
            chk("rst_rd_en", 32'(rd_en), 32'h0);
            chk("rst_wr_en", 32'(wr_en), 32'h0);
            chk("rst_cpu_din", 32'(cpu_din), 32'h0);
            chk("rst_wr_data", 32'(wr_data), 32'h0);
            chk("rst_cpu_rdy", 32'(cpu_rdy), 32'h0);
            chk("rst_irq_n", 32'(cpu_irq_n), 32'h1);
            a_sel  = 4'h0;
            a_selc = 0;
            a_rd   = 0;
            a_wr   = 0;
            m_din  = 8'h00;
            m_mask = 2'b11;
        end else begin
            chk("irq_n", 32'(cpu_irq_n), 32'(~|(~prev_irq & m_mask)));
            a_sel = a_sel | ~sel_n;
            if (sel_n != 4'hF) a_selc++;
            if (rd_en) a_rd++;
            if (wr_en) begin
                a_wr++;
                a_wd = wr_data;
            end
            if (cpu_rdy) begin
                if (q.size() == 0) begin
                    chk("rdy_unexpected", 32'(cpu_rdy), 32'h0);
                end else begin
                    t = q.pop_front();
                    chk("latency", 32'(nc - start_nc), 32'(t.lat));
                    chk("sel_pattern", 32'(a_sel), 32'(t.sel_mask));
                    chk("sel_cycles", 32'(a_selc), 32'(t.sel_cyc));
                    chk("rd_en_cycles", 32'(a_rd), 32'(t.rd_cyc));
                    chk("wr_en_cycles", 32'(a_wr), 32'(t.wr_cyc));
                    if (t.wr_cyc != 0) chk("wr_data", 32'(a_wd), 32'(t.wdat));
                    if (t.rd) m_din = t.reg_acc ? {6'b0, ~prev_irq} : t.din;
                    else if (t.reg_acc) m_mask = t.wdat[1:0];
                end
                a_sel  = 4'h0;
                a_selc = 0;
                a_rd   = 0;
                a_wr   = 0;
            end
            chk("cpu_din", 32'(cpu_din), 32'(m_din));
            if (cpu_req && req_real) start_nc = nc;
        end
        prev_res = res_n;
        prev_irq = irq_src_n;
    end

    // Interrupt sources wander independently of the bus traffic
    initial begin
        repeat (6) step();
        forever begin
            step();
            if ($urandom_range(0, 3) == 0) irq_src_n = 2'($urandom);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d transactions outstanding", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pool [10] = '{16'h0123, 16'h4567, 16'h7FF0, 16'h8000, 16'h8003,
                                   16'h8004, 16'h9000, 16'hBFFF, 16'hC000, 16'hFFFF};
        logic [15:0] a;
        repeat (3) step();
        res_n = 1'b1;
        step();
        do_txn(16'h0123, 1'b1, 8'h00, 32'hA1B2C35A, 1'b0, 1'b0);
        do_txn(16'h8001, 1'b0, 8'h3C, 32'h0,        1'b0, 1'b0);
        do_txn(16'h9000, 1'b1, 8'h00, 32'h12345678, 1'b0, 1'b0);
        do_txn(16'h8004, 1'b0, 8'h77, 32'h0,        1'b1, 1'b0);
        do_txn(16'h8002, 1'b1, 8'h00, 32'h00C30000, 1'b1, 1'b1);
        do_txn(16'h7FF0, 1'b0, 8'h01, 32'h0,        1'b0, 1'b0);
        do_txn(16'h7FF0, 1'b1, 8'h00, 32'h9988776E, 1'b0, 1'b0);
        reset_mid();
        do_txn(16'h8002, 1'b1, 8'h00, 32'h00E70000, 1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : pool[$urandom_range(0, 9)];
            do_txn(a, 1'($urandom), 8'($urandom), $urandom,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        repeat (2) step();
        chk("outstanding_txns", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
